// File: rtl/txepad.sv
// Transmit minimum-frame enforcer: passes TX bytes through and appends zero
// bytes to short frames until they reach MINBYTES (CRC is added downstream).
module txepad #(
  parameter int MINBYTES = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_last,
  input  logic       i_ready
);

  localparam int LGNCOUNT = (MINBYTES < 63)  ? 6 :
                            (MINBYTES < 127) ? 7 :
                            (MINBYTES < 255) ? 8 : 9;

  localparam logic [0:0] DATA = 1'b0;
  localparam logic [0:0] PAD  = 1'b1;

  // One extra bit so the +1 compare never wraps.
  localparam logic [LGNCOUNT:0] MIN_W = (LGNCOUNT+1)'(MINBYTES);
  localparam logic [LGNCOUNT:0] ONE_W = (LGNCOUNT+1)'(1);

  logic [0:0]          state;
  logic [LGNCOUNT-1:0] r_cnt;
  logic [LGNCOUNT:0]   cnt_inc;
  logic                advance;
  logic                accept;

  assign cnt_inc = {1'b0, r_cnt} + ONE_W;
  assign advance = !o_v || i_ready;
  assign o_ready = advance && (state == DATA);
  assign accept  = i_v && o_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= DATA;
      r_cnt  <= '0;
      o_v    <= 1'b0;
      o_d    <= 8'h00;
      o_last <= 1'b0;
    end else if (state == DATA) begin
      if (accept) begin
        o_v   <= 1'b1;
        o_d   <= i_d;
        // Long frames saturate so the count never exceeds MINBYTES.
        r_cnt <= (cnt_inc > MIN_W) ? MIN_W[LGNCOUNT-1:0] : cnt_inc[LGNCOUNT-1:0];
        if (!i_last) begin
          o_last <= 1'b0;
        end else if (i_en && (cnt_inc < MIN_W)) begin
          o_last <= 1'b0;
          state  <= PAD;
        end else begin
          o_last <= 1'b1;
          r_cnt  <= '0;
        end
      end else if (i_ready) begin
        o_v <= 1'b0;
      end
    end else if (advance) begin
      o_v    <= 1'b1;
      o_d    <= 8'h00;
      o_last <= 1'b0;
      r_cnt  <= cnt_inc[LGNCOUNT-1:0];
      if (cnt_inc == MIN_W) begin
        o_last <= 1'b1;
        r_cnt  <= '0;
        state  <= DATA;
      end
    end
  end

endmodule

// File: doc/txepad.md
# txepad

Transmit-side minimum-frame enforcer for the ethernet cores. It sits in the TX byte path ahead of CRC generation. It passes each outgoing frame through unchanged and, when a frame carries fewer than MINBYTES bytes, appends zero bytes until the frame reaches MINBYTES, so that the frame plus its 4-byte CRC meets the 64-byte ethernet minimum. It is the transmit counterpart of the receive-side runt-frame filter: on the receive side undersized frames are flagged, and here they are never generated.

## Interface
- MINBYTES, 60: minimum payload bytes per frame, excluding CRC. Legal range is 1..511.
- LGNCOUNT (localparam): the count width. It is 6 if MINBYTES<63, 7 if <127, 8 if <255, and 9 otherwise.

- i_clk  in  1  system clock.
- i_reset  in  1  reset. One clock; reset is asynchronous and active-high.
- i_en  in  1  padding enable. It is sampled on the cycle the input last byte is accepted.
- i_v  in  1  input byte valid.
- i_d  in  8  input byte.
- i_last  in  1  marks the final byte of the frame. It is qualified by i_v.
- o_ready  out  1  the input byte is accepted when i_v && o_ready.
- o_v  out  1  output byte valid. Registered.
- o_d  out  8  output byte. Registered.
- o_last  out  1  marks the final output byte of the frame. Registered.
- i_ready  in  1  downstream accepts the output byte when o_v && i_ready.

## Operation
- Reset state: state=DATA, r_cnt=0, o_v=0, o_d=8'h00, o_last=0.
- Definitions:
  - advance = !o_v || i_ready, meaning the output register may be loaded.
  - o_ready = advance && (state==DATA). This is combinational.
- State DATA, when the input byte is accepted:
  - Load o_v=1 and o_d=i_d.
  - Update r_cnt to r_cnt+1, saturating at MINBYTES.
  - Not i_last: set o_last=0.
  - i_last with i_en && (r_cnt+1 < MINBYTES): set o_last=0 and go to PAD.
  - Otherwise, on i_last: set o_last=1 and clear r_cnt to 0.
- State PAD, on advance:
  - Load o_v=1 and o_d=8'h00.
  - Update r_cnt to r_cnt+1.
  - If r_cnt+1 == MINBYTES, set o_last=1, clear r_cnt to 0, and return to DATA.
- In any state, if the output is accepted (o_v && i_ready) and nothing new is loaded, o_v drops to 0.
- Count width: r_cnt is LGNCOUNT bits and never exceeds MINBYTES. Comparisons are done at LGNCOUNT+1 bits so there is no wrap.
- Frames of MINBYTES bytes or longer pass byte-for-byte unmodified.
- i_en=0 disables padding for that frame only.
- A frame is at least one byte long, since i_last always accompanies a valid byte. A zero-length frame is not representable.
- While in PAD, o_ready=0. The next frame's first byte waits and is never merged into the padding.
- Upstream must hold i_v, i_d and i_last stable while o_ready=0.
- Reset mid-frame or mid-pad aborts the frame immediately. The output shows o_v=0 asynchronously, and no o_last is emitted for the aborted frame.

## Timing
- Latency is 1 cycle from input acceptance to o_v/o_d.
- Throughput is 1 byte per clock when i_ready=1.
- The first pad byte appears the cycle after the short frame's last input byte is presented on the output.
- Padding emits exactly MINBYTES-N bytes back to back when i_ready stays high, for an N-byte frame.
- o_last is asserted on exactly one output byte per frame.
- While o_v=1 && !i_ready, o_v, o_d and o_last hold stable.
- The next frame's first byte can be accepted in the same cycle the pad byte carrying o_last is loaded? No. It is accepted at the earliest on the cycle after the return to DATA, provided advance holds.

## Test plan
- 10-byte frame (bytes 1..10), i_en=1, i_ready=1: 60 output bytes, namely bytes 1..10 then 50×00. o_last only on byte 60. o_ready is low for 50 cycles.
- 60-byte frame, i_en=1: 60 bytes out identical to the input, o_last on byte 60, no pad cycles. A 100-byte frame likewise passes with 100 bytes, and r_cnt saturates at 60.
- 10-byte frame, i_en=0: exactly 10 bytes out with o_last on byte 10. A following frame with i_en=1 is padded normally.
- 59-byte frame with random i_ready (about 50% duty): 60 bytes out, the last being 00 with o_last. No byte is lost or duplicated, and outputs are stable while stalled.
- Back-to-back frames of 1 byte and 5 bytes with i_v held high: first output is 1 data byte plus 59 zeros, second is 5 data bytes plus 55 zeros. The second frame's first byte is not accepted until PAD completes.
- Assert i_reset during the 20th pad byte: o_v=0 immediately with no o_last. After release, a 64-byte frame passes unmodified with r_cnt starting from 0.
